seq_detector: RTL and testbench

// - Serial bit-pattern detector: samples one bit per clock on serIn, raises w when the last PAT_LEN bits match PATTERN.
// - Moore FSM: w depends only on state, so it is glitch-free and registered.
// - Sits after a serial receiver. One instance serves as RTL golden model, one as gate-level netlist; both must match cycle-for-cycle.

---
 rtl/seq_detector.sv | 87 ++++++++
 tb/tb_seq_detector.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detector.sv
// Moore serial pattern detector: w is high for the cycle in which the last PAT_LEN
// sampled bits of serIn equal PATTERN (MSB received first).
module seq_detector #(
    parameter int               PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1111,
    parameter bit               OVERLAP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serIn,
    output logic       w,
    output logic [3:0] state_dbg
);

    // State k (0..PAT_LEN-1) = length of the matched pattern prefix; SM = full match.
    localparam logic [3:0] S0 = 4'd0;
    localparam logic [3:0] SM = 4'(PAT_LEN);

    // Pattern bit j in arrival order (j = 0 is the first bit received).
    function automatic logic pat_bit(input int j);
        logic [8:0] pv;
        pv = 9'(PATTERN) >> (PAT_LEN - 1 - j);
        return pv[0];
    endfunction

    // Next-state table indexed by {state, bit}. Each entry is the longest pattern
    // prefix that is a suffix of (matched prefix + new bit), i.e. the KMP failure
    // closure. Unused entries stay 0 so illegal states fall back to S0.
    function automatic logic [127:0] build_tbl();
        logic [127:0] tbl;
        logic [8:0]   s;
        logic [8:0]   sh;
        logic         ok;
        int           k_eff;
        int           n;
        int           best;
        tbl = '0;
        for (int k = 0; k <= PAT_LEN; k++) begin
            for (int b = 0; b < 2; b++) begin
                k_eff = (k == PAT_LEN && OVERLAP == 1'b0) ? 0 : k;
                s = '0;
                for (int i = 0; i < k_eff; i++)
                    s = s | (9'(pat_bit(i)) << i);
                s = s | (9'(b[0]) << k_eff);
                n = k_eff + 1;
                best = 0;
                for (int l = 1; l <= PAT_LEN; l++) begin
                    if (l <= n) begin
                        ok = 1'b1;
                        for (int j = 0; j < l; j++) begin
                            sh = s >> (n - l + j);
                            if (sh[0] != pat_bit(j))
                                ok = 1'b0;
                        end
                        if (ok)
                            best = l;
                    end
                end
                tbl = tbl | (128'(best[3:0]) << ((k * 2 + b) * 4));
            end
        end
        return tbl;
    endfunction

    localparam logic [31:0][3:0] NEXT_TBL = build_tbl();

    logic [3:0] state;
    logic [3:0] next_state;

    always_comb begin
        next_state = NEXT_TBL[{state, serIn}];
    end

    // w is registered from next_state so it is a clean flop output equal to (state == SM).
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S0;
            w     <= 1'b0;
        end else begin
            state <= next_state;
            w     <= (next_state == SM);
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_seq_detector.sv
// Bench for seq_detector: four parameterisations driven by one serial stream,
// directed scenarios followed by random bits, checked against a bit-history model.
module tb_seq_detector;

    logic clk;
    logic rst;
    logic ser_in;

    logic       w_def, w_nov, w_1101, w_p5;
    logic [3:0] st_def, st_nov, st_1101, st_p5;

    int passed;
    int total;

    // Reference model: per instance, the received bits since reset (or since the
    // last match when overlap is off); a match is the last len bits equal to pat.
    int         m_len  [4];
    logic [7:0] m_pat  [4];
    logic [7:0] m_mask [4];
    bit         m_ovl  [4];
    logic [7:0] m_hist [4];
    int         m_cnt  [4];
    logic       m_exp  [4];

    seq_detector #(.PAT_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b1)) u_def (
        .clk(clk), .rst(rst), .serIn(ser_in), .w(w_def), .state_dbg(st_def));
    seq_detector #(.PAT_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b0)) u_nov (
        .clk(clk), .rst(rst), .serIn(ser_in), .w(w_nov), .state_dbg(st_nov));
    seq_detector #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1)) u_1101 (
        .clk(clk), .rst(rst), .serIn(ser_in), .w(w_1101), .state_dbg(st_1101));
    seq_detector #(.PAT_LEN(5), .PATTERN(5'b10010), .OVERLAP(1'b1)) u_p5 (
        .clk(clk), .rst(rst), .serIn(ser_in), .w(w_p5), .state_dbg(st_p5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    endtask

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_update(input logic r, input logic b);
        for (int i = 0; i < 4; i++) begin
            if (!r) begin
                m_cnt[i] = 0;
                m_exp[i] = 1'b0;
            end else begin
                m_hist[i] = {m_hist[i][6:0], b};
                m_cnt[i]++;
                m_exp[i] = (m_cnt[i] >= m_len[i]) && ((m_hist[i] & m_mask[i]) == m_pat[i]);
                if (m_exp[i] && !m_ovl[i])
                    m_cnt[i] = 0;
            end
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit after posedge, then
    // wiggle serIn between edges (it must not matter).
    task automatic step(input logic r, input logic b);
        @(negedge clk);
        rst    = r;
        ser_in = b;
        @(posedge clk);
        #1;
        model_update(r, b);
        check("model_w_def", w_def, m_exp[0]);
        check("model_w_nov", w_nov, m_exp[1]);
        check("model_w_1101", w_1101, m_exp[2]);
        check("model_w_p5", w_p5, m_exp[3]);
        #1 ser_in = ~b;
    endtask

    logic [7:0] seq8;
    logic [7:0] exp8;
    logic       r_rand;
    logic       b_rand;

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b0;
        ser_in = 1'b0;
        m_len[0] = 4; m_pat[0] = 8'b1111;  m_ovl[0] = 1'b1;
        m_len[1] = 4; m_pat[1] = 8'b1111;  m_ovl[1] = 1'b0;
        m_len[2] = 4; m_pat[2] = 8'b1101;  m_ovl[2] = 1'b1;
        m_len[3] = 5; m_pat[3] = 8'b10010; m_ovl[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_mask[i] = 8'((1 << m_len[i]) - 1);
            m_hist[i] = '0;
            m_cnt[i]  = 0;
            m_exp[i]  = 1'b0;
        end

        // Reset held with serIn=1: no detection.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1);
            check("rst_hold_w", w_def, 1'b0);
        end
        check4("rst_state_def", st_def, 4'd0);
        check4("rst_state_nov", st_nov, 4'd0);
        check4("rst_state_1101", st_1101, 4'd0);
        check4("rst_state_p5", st_p5, 4'd0);

        // Release: needs four sampled ones.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            check("rst_release_early", w_def, 1'b0);
        end
        step(1'b1, 1'b1);
        check("rst_release_fourth", w_def, 1'b1);

        // Default pattern with overlapping repeat.
        step(1'b0, 1'b0);
        seq8 = 8'b00111110;
        exp8 = 8'b00000110;
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, seq8[i]);
            check("default_seq", w_def, exp8[i]);
        end

        // Mismatch recovery.
        step(1'b0, 1'b0);
        seq8 = 8'b01101111;
        exp8 = 8'b00000001;
        for (int i = 6; i >= 0; i--) begin
            step(1'b1, seq8[i]);
            check("mismatch_seq", w_def, exp8[i]);
        end

        // Mid-pattern reset discards partial match.
        step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            check("mid_rst_pre", w_def, 1'b0);
        end
        step(1'b0, 1'b1);
        check("mid_rst_edge", w_def, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            check("mid_rst_post", w_def, 1'b0);
        end
        step(1'b1, 1'b1);
        check("mid_rst_match", w_def, 1'b1);

        // Reset while in the match state.
        step(1'b0, 1'b1);
        check("rst_in_match", w_def, 1'b0);

        // Non-overlapping search: eight ones.
        exp8 = 8'b00010001;
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, 1'b1);
            check("no_overlap_w", w_nov, exp8[i]);
        end

        // Pattern 1101 with overlap.
        step(1'b0, 1'b0);
        seq8 = 8'b01101101;
        exp8 = 8'b00001001;
        for (int i = 6; i >= 0; i--) begin
            step(1'b1, seq8[i]);
            check("pat_1101", w_1101, exp8[i]);
        end

        // Random stream with occasional resets.
        for (int i = 0; i < 800; i++) begin
            r_rand = ($urandom_range(0, 31) != 0);
            b_rand = 1'($urandom_range(0, 1));
            step(r_rand, b_rand);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
